seq_signed_divider: RTL

- Multi-cycle radix-2 non-restoring divider; the inverse operation to the team's sequential Booth multiplier.
- Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, giving a WIDTH-bit quotient and a WIDTH-bit remainder.
- Two modes, selected per operation: two's-complement signed or unsigned.
- Sits beside the multiplier in the arithmetic datapath and uses a start/done handshake.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_sign_unit.sv | 53 +++++
 rtl/seq_signed_divider.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the sequential signed/unsigned divider.
//   state_e        : controller states
//   DEFAULT_WIDTH  : default divisor/quotient/remainder width
//   cntWidth()     : width of the iteration counter for a given WIDTH
package div_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_e;

  // The counter must be able to hold WIDTH itself, hence the +1.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_sign_unit.sv
// div_sign_unit -- combinational sign handling around the unsigned divider core.
//   isSigned_i     : operands are two's complement
//   dividend_i     : raw 2*WIDTH-bit dividend
//   divisor_i      : raw WIDTH-bit divisor
//   signQ_i        : quotient must be negated
//   signR_i        : remainder must be negated (dividend sign)
//   qMag_i, rMag_i : unsigned quotient/remainder magnitudes
//   dividendMag_o  : |dividend| (-2^(2W-1) maps to 2^(2W-1), still fits unsigned)
//   divisorMag_o   : |divisor|
//   dividendNeg_o  : dividend is negative
//   divisorNeg_o   : divisor is negative
//   quotient_o     : signed-corrected quotient
//   remainder_o    : signed-corrected remainder
//   rangeOvf_o     : quotient magnitude does not fit the signed WIDTH-bit range
module div_sign_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 isSigned_i,
  input  logic [2*WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]     divisor_i,
  input  logic                 signQ_i,
  input  logic                 signR_i,
  input  logic [WIDTH-1:0]     qMag_i,
  input  logic [WIDTH-1:0]     rMag_i,
  output logic [2*WIDTH-1:0]   dividendMag_o,
  output logic [WIDTH-1:0]     divisorMag_o,
  output logic                 dividendNeg_o,
  output logic                 divisorNeg_o,
  output logic [WIDTH-1:0]     quotient_o,
  output logic [WIDTH-1:0]     remainder_o,
  output logic                 rangeOvf_o
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Operand magnitudes; unsigned mode never reports a negative operand.
  assign dividendNeg_o = isSigned_i & dividend_i[2*WIDTH-1];
  assign divisorNeg_o  = isSigned_i & divisor_i[WIDTH-1];
  assign dividendMag_o = dividendNeg_o ? -dividend_i : dividend_i;
  assign divisorMag_o  = divisorNeg_o ? -divisor_i : divisor_i;

  // Truncation toward zero for the quotient; remainder follows the dividend
  // sign and a zero remainder stays zero.
  assign quotient_o  = signQ_i ? -qMag_i : qMag_i;
  assign remainder_o = (signR_i && (rMag_i != '0)) ? -rMag_i : rMag_i;

  // A negative result may reach -2^(W-1); a positive one only 2^(W-1)-1.
  assign rangeOvf_o = isSigned_i & (signQ_i ? (qMag_i > MAX_NEG) : (qMag_i > MAX_POS));

endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider -- multi-cycle radix-2 non-restoring divider,
// 2*WIDTH-bit dividend by WIDTH-bit divisor, signed or unsigned per operation.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request, only accepted in IDLE
//   is_signed           : two's-complement operands when 1 (latched with start)
//   dividend, divisor   : operands (latched with start)
//   busy                : operation in progress (PREP, ITER, FIX)
//   done                : one-cycle completion pulse
//   quotient, remainder : results, held until the next done
//   div_by_zero         : divisor was zero
//   overflow            : quotient does not fit WIDTH bits in the selected mode
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = cntWidth(WIDTH);

  state_e             state_q;
  logic [2*WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0]   divisor_q;
  logic               isSigned_q;
  logic               signQ_q;
  logic               signR_q;
  logic [WIDTH-1:0]   divMag_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   lo_q;
  logic [CW-1:0]      count_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   remOut_q;
  logic               dbz_q;
  logic               ovf_q;

  logic [WIDTH:0]     remShift_d;
  logic [WIDTH:0]     remIter_d;
  logic [WIDTH-1:0]   loIter_d;
  logic [WIDTH-1:0]   remFix_d;

  logic [2*WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0]   divisorMag;
  logic               dividendNeg;
  logic               divisorNeg;
  logic [WIDTH-1:0]   quotSigned;
  logic [WIDTH-1:0]   remSigned;
  logic               rangeOvf;
  logic               earlyOvf;

  div_sign_unit #(.WIDTH(WIDTH)) uSignUnit (
    .isSigned_i    (isSigned_q),
    .dividend_i    (dividend_q),
    .divisor_i     (divisor_q),
    .signQ_i       (signQ_q),
    .signR_i       (signR_q),
    .qMag_i        (lo_q),
    .rMag_i        (remFix_d),
    .dividendMag_o (dividendMag),
    .divisorMag_o  (divisorMag),
    .dividendNeg_o (dividendNeg),
    .divisorNeg_o  (divisorNeg),
    .quotient_o    (quotSigned),
    .remainder_o   (remSigned),
    .rangeOvf_o    (rangeOvf)
  );

  // A quotient of 2^WIDTH or more is detectable before iterating.
  assign earlyOvf = (dividendMag[2*WIDTH-1:WIDTH] >= divisorMag);

  // One non-restoring step. The partial remainder always lands in
  // [-|d|, |d|), so W+1 bits hold it exactly even though the shifted value
  // may wrap. lo_q holds the unconsumed dividend bits on the left and
  // collects quotient bits on the right.
  always_comb begin
    remShift_d = {rem_q[WIDTH-1:0], lo_q[WIDTH-1]};
    if (rem_q[WIDTH]) begin
      remIter_d = remShift_d + {1'b0, divMag_q};
    end else begin
      remIter_d = remShift_d - {1'b0, divMag_q};
    end
    loIter_d = {lo_q[WIDTH-2:0], ~remIter_d[WIDTH]};
    remFix_d = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + divMag_q) : rem_q[WIDTH-1:0];
  end

  // Controller plus iteration registers; results and flags change only on
  // entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      isSigned_q <= 1'b0;
      signQ_q    <= 1'b0;
      signR_q    <= 1'b0;
      divMag_q   <= '0;
      rem_q      <= '0;
      lo_q       <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      remOut_q   <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dividend_q <= dividend;
            divisor_q  <= divisor;
            isSigned_q <= is_signed;
            busy_q     <= 1'b1;
            state_q    <= PREP;
          end
        end
        PREP: begin
          signQ_q  <= dividendNeg ^ divisorNeg;
          signR_q  <= dividendNeg;
          divMag_q <= divisorMag;
          if (divisor_q == '0) begin
            dbz_q    <= 1'b1;
            ovf_q    <= 1'b0;
            quot_q   <= '0;
            remOut_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (earlyOvf) begin
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b1;
            quot_q   <= '0;
            remOut_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            rem_q   <= {1'b0, dividendMag[2*WIDTH-1:WIDTH]};
            lo_q    <= dividendMag[WIDTH-1:0];
            count_q <= '0;
            state_q <= ITER;
          end
        end
        ITER: begin
          rem_q   <= remIter_d;
          lo_q    <= loIter_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          dbz_q <= 1'b0;
          if (rangeOvf) begin
            ovf_q    <= 1'b1;
            quot_q   <= '0;
            remOut_q <= '0;
          end else begin
            ovf_q    <= 1'b0;
            quot_q   <= quotSigned;
            remOut_q <= remSigned;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remOut_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
